// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the dual-port memory arbiter.
package mem_arb_pkg;

    localparam int MAX_REQ  = 8;
    localparam int ADDR_MAX = 64;

    // Response tag: which requester owns the response arriving next cycle.
    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } port_tag_t;

    // Byte address to word address; callers truncate to the memory width.
    function automatic logic [ADDR_MAX-1:0] word_addr(input logic [ADDR_MAX-1:0] byte_addr,
                                                      input int unsigned       off_bits);
        return byte_addr >> off_bits;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Circular find-first-set: first requesting, non-excluded index at or after start_i.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     excl_i,
    input  logic [PTR_W-1:0] start_i,
    output logic             valid_o,
    output logic [PTR_W-1:0] idx_o
);

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        int pos;
        pos     = 0;
        valid_o = 1'b0;
        idx_o   = '0;
        for (int off = N - 1; off >= 0; off--) begin
            pos = (int'(start_i) + off) % N;
            if (req_i[pos] && !excl_i[pos]) begin
                valid_o = 1'b1;
                idx_o   = PTR_W'(pos);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto the two
// memory ports, deferring port B whenever it would form a same-word pair
// containing a write, and routing the one-cycle responses back.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int M_ADDR_WIDTH = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_ni,
    input  logic [N_REQ-1:0]                      req_i,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]      addr_i,
    input  logic [N_REQ-1:0]                      we_i,
    input  logic [N_REQ-1:0][DATA_WIDTH/8-1:0]    be_i,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]      wdata_i,
    output logic [N_REQ-1:0]                      gnt_o,
    output logic [N_REQ-1:0]                      rvalid_o,
    output logic [N_REQ-1:0]                      err_o,
    output logic [N_REQ-1:0][DATA_WIDTH-1:0]      rdata_o,
    output logic                                  mem_req_a_o,
    output logic [M_ADDR_WIDTH-1:0]               mem_addr_a_o,
    output logic                                  mem_we_a_o,
    output logic [DATA_WIDTH/8-1:0]               mem_be_a_o,
    output logic [DATA_WIDTH-1:0]                 mem_wdata_a_o,
    input  logic                                  mem_gnt_a_i,
    input  logic                                  mem_rvalid_a_i,
    input  logic                                  mem_err_a_i,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata_a_i,
    output logic                                  mem_req_b_o,
    output logic [M_ADDR_WIDTH-1:0]               mem_addr_b_o,
    output logic                                  mem_we_b_o,
    output logic [DATA_WIDTH/8-1:0]               mem_be_b_o,
    output logic [DATA_WIDTH-1:0]                 mem_wdata_b_o,
    input  logic                                  mem_gnt_b_i,
    input  logic                                  mem_rvalid_b_i,
    input  logic                                  mem_err_b_i,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata_b_i,
    output logic [CNT_WIDTH-1:0]                  collision_cnt_o
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BE_W);
    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    port_tag_t               tag_a_q, tag_a_d, tag_b_q, tag_b_d;
    logic [CNT_WIDTH-1:0]    coll_cnt_q, coll_cnt_d;

    logic                    a_valid, b_valid;
    logic [PTR_W-1:0]        a_idx, b_idx, b_start;
    logic [N_REQ-1:0]        a_mask;
    logic [M_ADDR_WIDTH-1:0] wa_a, wa_b;
    logic                    collision, gnt_a, gnt_b;
    logic [N_REQ-1:0]        hit_a, hit_b;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_REQ - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    rr_pick #(.N(N_REQ), .PTR_W(PTR_W)) u_pick_a (
        .req_i   (req_i),
        .excl_i  ('0),
        .start_i (rr_ptr_q),
        .valid_o (a_valid),
        .idx_o   (a_idx)
    );

    assign b_start = ptr_inc(a_idx);

    rr_pick #(.N(N_REQ), .PTR_W(PTR_W)) u_pick_b (
        .req_i   (req_i),
        .excl_i  (a_mask),
        .start_i (b_start),
        .valid_o (b_valid),
        .idx_o   (b_idx)
    );

    assign wa_a = M_ADDR_WIDTH'(word_addr(ADDR_MAX'(addr_i[a_idx]), OFF));
    assign wa_b = M_ADDR_WIDTH'(word_addr(ADDR_MAX'(addr_i[b_idx]), OFF));

    // A same-word pair is only safe when both sides read.
    assign collision = a_valid && b_valid && (wa_a == wa_b) && (we_i[a_idx] || we_i[b_idx]);
    assign gnt_a     = rst_ni && a_valid;
    assign gnt_b     = rst_ni && b_valid && !collision;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign a_mask[gi]   = (a_idx == PTR_W'(gi));
            assign gnt_o[gi]    = (gnt_a && (a_idx == PTR_W'(gi))) || (gnt_b && (b_idx == PTR_W'(gi)));
            assign hit_a[gi]    = tag_a_q.valid && (tag_a_q.idx == 3'(gi));
            assign hit_b[gi]    = tag_b_q.valid && (tag_b_q.idx == 3'(gi));
            assign rvalid_o[gi] = (hit_a[gi] && mem_rvalid_a_i) || (hit_b[gi] && mem_rvalid_b_i);
            assign err_o[gi]    = (hit_a[gi] && mem_err_a_i) || (hit_b[gi] && mem_err_b_i);
            assign rdata_o[gi]  = hit_a[gi] ? mem_rdata_a_i : (hit_b[gi] ? mem_rdata_b_i : '0);
        end
    endgenerate

    assign mem_req_a_o   = gnt_a;
    assign mem_addr_a_o  = gnt_a ? wa_a : '0;
    assign mem_we_a_o    = gnt_a && we_i[a_idx];
    assign mem_be_a_o    = gnt_a ? be_i[a_idx] : '0;
    assign mem_wdata_a_o = gnt_a ? wdata_i[a_idx] : '0;

    assign mem_req_b_o   = gnt_b;
    assign mem_addr_b_o  = gnt_b ? wa_b : '0;
    assign mem_we_b_o    = gnt_b && we_i[b_idx];
    assign mem_be_b_o    = gnt_b ? be_i[b_idx] : '0;
    assign mem_wdata_b_o = gnt_b ? wdata_i[b_idx] : '0;

    assign collision_cnt_o = coll_cnt_q;

    // Next pointer, response tags and saturating collision count.
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        tag_a_d.valid = gnt_a;
        tag_a_d.idx   = 3'(a_idx);
        tag_b_d.valid = gnt_b;
        tag_b_d.idx   = 3'(b_idx);
        coll_cnt_d    = coll_cnt_q;
        if (gnt_b) begin
            rr_ptr_d = ptr_inc(b_idx);
        end else if (gnt_a) begin
            rr_ptr_d = ptr_inc(a_idx);
        end
        if (collision && (coll_cnt_q != '1)) begin
            coll_cnt_d = coll_cnt_q + CNT_WIDTH'(1);
        end
    end

    // State registers; reset drops any response still in flight.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            tag_a_q    <= '0;
            tag_b_q    <= '0;
            coll_cnt_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            tag_a_q    <= tag_a_d;
            tag_b_q    <= tag_b_d;
            coll_cnt_q <= coll_cnt_d;
        end
    end

    a_mem_gnt_a: assert property (@(posedge clk) disable iff (!rst_ni) mem_req_a_o |-> mem_gnt_a_i);
    a_mem_gnt_b: assert property (@(posedge clk) disable iff (!rst_ni) mem_req_b_o |-> mem_gnt_b_i);
    a_no_wcoll:  assert property (@(posedge clk) disable iff (!rst_ni)
                     !(mem_req_a_o && mem_req_b_o && (mem_addr_a_o == mem_addr_b_o) && (mem_we_a_o || mem_we_b_o)));

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the two ports of the dual-port data memory wrapper between `N_REQ` OBI-style requesters (scalar core LSU, vector unit, DMA, debug). Each cycle it grants up to two requesters round-robin, one per memory port. It never issues a same-word access pair containing a write, so the memory's collision error is never raised. It routes each one-cycle-latency response back to the requester that issued it.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, 32, data width; byte enables are `DATA_WIDTH/8`
- `ADDR_WIDTH`, 32, requester byte-address width
- `M_ADDR_WIDTH`, 16, memory word-address width; word address = `addr[M_ADDR_WIDTH+$clog2(DATA_WIDTH/8)-1:$clog2(DATA_WIDTH/8)]`
- `CNT_WIDTH`, 16, width of the collision counter

Ports (requester buses are packed arrays indexed `[N_REQ-1:0]`):
- `clk` in 1: single clock, rising edge
- `rst_ni` in 1: asynchronous, active-low reset
- `req_i` in N_REQ: request per requester
- `addr_i` in N_REQ×ADDR_WIDTH: byte address
- `we_i` in N_REQ: write enable
- `be_i` in N_REQ×DATA_WIDTH/8: byte enables
- `wdata_i` in N_REQ×DATA_WIDTH: write data
- `gnt_o` out N_REQ: grant, combinational
- `rvalid_o` out N_REQ: response valid
- `err_o` out N_REQ: response error
- `rdata_o` out N_REQ×DATA_WIDTH: read data
- `mem_req_a_o`, `mem_addr_a_o`, `mem_we_a_o`, `mem_be_a_o`, `mem_wdata_a_o` out: port A request to the memory wrapper
- `mem_gnt_a_i`, `mem_rvalid_a_i`, `mem_err_a_i`, `mem_rdata_a_i` in: port A response
- `mem_*_b_*`: identical set for port B
- `collision_cnt_o` out CNT_WIDTH: saturating count of collision deferrals

## Operation
- `rr_ptr` (`$clog2(N_REQ)` bits) names the highest-priority requester.
- **Port A pick:** first index `i` with `req_i[i]`, searching circularly from `rr_ptr`.
- **Port B pick:** next requesting index circularly after the A pick, excluding A.
- **Collision:** the A and B picks have equal word addresses and `we_i` of either is 1.
  - Port B idles this cycle; no third requester is tried.
  - `collision_cnt_o` increments, saturating at all-ones.
- Two reads to the same word are both granted.
- `gnt_o[k]` = 1 iff `k` is the A pick or a non-deferred B pick. At most two bits are set.
- Memory outputs are muxed from the picked requester. `mem_req_x_o` = 0 when the port has no pick.
- **Pointer update on any grant:** `rr_ptr <= (last granted index) + 1 mod N_REQ`.
  - Last granted index = B pick if B was granted, else A pick.
  - Wrap-around from `N_REQ-1` to 0.
- **Response routing:** per-port tag register `{valid, idx}` is captured at the grant edge.
  - Next cycle: `rvalid_o[idx]` = `mem_rvalid_x_i`, `rdata_o[idx]` = `mem_rdata_x_i`, `err_o[idx]` = `mem_err_x_i`.
  - Non-addressed requesters see `rvalid`=0, `err`=0, `rdata`=0.
- **Reset values:** all `gnt_o`, `rvalid_o`, `err_o` = 0; `rdata_o` = 0; all `mem_req_*` = 0 while `rst_ni` = 0; `rr_ptr` = 0; tags invalid; `collision_cnt_o` = 0.
- **Reset mid-operation:** tags clear asynchronously. A response pending at reset assertion is dropped, never delivered.

## Timing
- Grant latency 0: `gnt_o` is in the same cycle as `req_i`, combinational from `req_i`, `addr_i`, `we_i`, `rr_ptr`.
- Requesters hold `req`, `addr`, `we`, `be`, `wdata` stable until granted; withdrawing `req` before grant is permitted.
- Response latency exactly 1 cycle after the grant edge; no backpressure on responses.
- A requester may re-request in the cycle of its `rvalid`. Throughput is one access per requester per cycle when uncontended.
- A deferred B requester is granted no later than 1 cycle later: `rr_ptr` lands on it, so it becomes the A pick.
- `mem_gnt_x_i` is always asserted with `mem_req_x_o` and is not used for sequencing; it is checked only by assertion.

## Structure
- Package `mem_arb_pkg` holds:
  - `typedef struct packed {logic valid; logic [2:0] idx;} port_tag_t`
  - `localparam MAX_REQ = 8`
  - function `word_addr()` that extracts the word address from a byte address
- Sub-module `rr_pick`: circular find-first-set from a start pointer with an exclude mask. Instantiated twice (A, B).

## Test plan
- **Single requester:** req 2 read `0x40`, `rr_ptr`=0 → `gnt_o`=`4'b0100`, port A word addr `0x10`; next cycle `rvalid_o[2]`=1 with memory data.
- **Two reads, different words:** req 0 and 3, `rr_ptr`=0 → A=0, B=3, both granted; `rr_ptr`→0 (3+1 wrap); responses routed to 0 and 3.
- **Write collision:** req 1 write `0x100`, req 2 read `0x100`, `rr_ptr`=1 → only 1 granted, `collision_cnt_o`=1; next cycle 2 granted on port A.
- **Same-word reads:** req 0 and 1 both read `0x8` → both granted, `collision_cnt_o` unchanged.
- **Fairness:** all 4 requesting continuously for 8 cycles → each granted exactly 4 times; grant pairs (0,1),(2,3),(0,1)…
- **Reset mid-flight:** grant req 1, assert `rst_ni`=0 before the next edge → `rvalid_o`=0 throughout; after release `rr_ptr`=0 and `collision_cnt_o`=0.
